// File: rtl/grostl_shift_bytes_pipe.sv
// grostl_shift_bytes_pipe: pipelined Grostl ShiftBytes for P/Q permutations with valid/ready handshake
// Ports: clk, rst_n (async, active-low), flush (sync clear of all stages);
//        in_valid/in_ready/in_mode/in_data  upstream transaction (state packed column-major, column 0 MSB);
//        out_valid/out_ready/out_mode/out_data  downstream transaction; busy = any stage holds valid data.
module grostl_shift_bytes_pipe #(
    parameter int COLS = 8,
    parameter int LAT  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic [COLS*64-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_mode,
    output logic [COLS*64-1:0] out_data,
    output logic               busy
);
    if (COLS != 8 && COLS != 16) begin : g_bad_cols
        $error("grostl_shift_bytes_pipe: COLS must be 8 or 16");
    end
    if (LAT != 1 && LAT != 2) begin : g_bad_lat
        $error("grostl_shift_bytes_pipe: LAT must be 1 or 2");
    end
    logic [0:COLS-1][0:7][7:0]   w_in;
    logic [0:COLS-1][0:7][7:0]   w_perm;
    logic [LAT-1:0]              w_load;
    logic [LAT-1:0]              r_v;
    logic [LAT-1:0]              r_mode;
    logic [LAT-1:0][COLS*64-1:0] r_data;
    assign w_in = in_data;
    // Row r of output column c takes row r of input column c+S[r]; constant indices, so pure wiring.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        for (genvar r = 0; r < 8; r++) begin : g_row
            localparam int SP = (COLS == 16 && r == 7) ? 11 : r;
            localparam int SQ = r >= 4 ? 2 * r - 8 : (COLS == 16 && r == 3) ? 11 : 2 * r + 1;
            assign w_perm[c][r] = in_mode ? w_in[(c + SQ) % COLS][r] : w_in[(c + SP) % COLS][r];
        end
    end
    // Stage k can load when downstream drains or any stage from k to the output has a hole.
    for (genvar k = 0; k < LAT; k++) begin : g_load
        assign w_load[k] = out_ready || !(&r_v[LAT-1:k]);
    end
    assign in_ready  = !flush && w_load[0];
    assign out_valid = r_v[LAT-1];
    assign out_mode  = r_mode[LAT-1];
    assign out_data  = r_data[LAT-1];
    assign busy      = |r_v;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v    <= '0;
            r_mode <= '0;
            r_data <= '0;
        end else begin
            if (w_load[0]) begin
                r_v[0]    <= in_valid && in_ready;
                r_mode[0] <= in_mode;
                r_data[0] <= w_perm;
            end
            for (int k = 1; k < LAT; k++) begin
                if (w_load[k]) begin
                    r_v[k]    <= r_v[k-1];
                    r_mode[k] <= r_mode[k-1];
                    r_data[k] <= r_data[k-1];
                end
            end
            if (flush) r_v <= '0;
        end
    end
endmodule

// File: tb/tb_grostl_shift_bytes_pipe.sv
// tb_grostl_shift_bytes_pipe: scoreboard bench for an 8-column LAT=1 and a 16-column LAT=2 instance
module tb_grostl_shift_bytes_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic          flush     [2];
    logic          in_valid  [2];
    logic          in_ready  [2];
    logic          in_mode   [2];
    logic [1023:0] in_data   [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic          out_mode  [2];
    logic [1023:0] out_data  [2];
    logic          busy      [2];
    int total = 0;
    int bad = 0;
    typedef struct packed {
        logic          m;
        logic [1023:0] d;
    } item_t;
    item_t q0[$];
    item_t q1[$];
    localparam int TAB [4][8] = '{'{0, 1, 2, 3, 4, 5, 6, 7}, '{1, 3, 5, 7, 0, 2, 4, 6},
                                  '{0, 1, 2, 3, 4, 5, 6, 11}, '{1, 3, 5, 11, 0, 2, 4, 6}};
    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int C = g ? 16 : 8;
        localparam int L = g ? 2 : 1;
        logic [C*64-1:0] od;
        grostl_shift_bytes_pipe #(.COLS(C), .LAT(L)) dut (
            .clk(clk), .rst_n(rst_n), .flush(flush[g]),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_mode(in_mode[g]),
            .in_data(in_data[g][C*64-1:0]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_mode(out_mode[g]),
            .out_data(od), .busy(busy[g])
        );
        assign out_data[g] = 1024'(od);
    end
    function automatic int bpos(input int cols, input int c, input int r);
        return ((cols - 1 - c) * 8 + 7 - r) * 8;
    endfunction
    // Reference: out byte(c,r) = in byte((c + S[r]) mod cols, r)
    function automatic logic [1023:0] model(input logic [1023:0] d, input logic m, input int cols);
        logic [1023:0] o;
        int s;
        o = '0;
        for (int c = 0; c < cols; c++)
            for (int r = 0; r < 8; r++) begin
                s = TAB[(cols == 16 ? 2 : 0) + int'(m)][r];
                o[bpos(cols, c, r) +: 8] = d[bpos(cols, (c + s) % cols, r) +: 8];
            end
        return o;
    endfunction
    function automatic logic [1023:0] pat(input int cols);
        logic [1023:0] o;
        o = '0;
        for (int c = 0; c < cols; c++)
            for (int r = 0; r < 8; r++) o[bpos(cols, c, r) +: 8] = 8'(8 * c + r);
        return o;
    endfunction
    function automatic logic [1023:0] rnd();
        logic [1023:0] o;
        for (int w = 0; w < 32; w++) o[w*32 +: 32] = $urandom;
        return o;
    endfunction
    function automatic logic [63:0] col(input int i, input int c);
        return out_data[i][((i == 0 ? 8 : 16) - 1 - c) * 64 +: 64];
    endfunction
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask
    task automatic chkb(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask
    task automatic chkd(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
        total++;
        if (act !== exp) begin
            int w;
            w = 0;
            while (w < 15 && act[w*64 +: 64] === exp[w*64 +: 64]) w++;
            bad++;
            $display("FAIL %s: word %0d got %h want %h", nm, w, act[w*64 +: 64], exp[w*64 +: 64]);
        end
    endtask
    task automatic send(input int i, input logic m, input logic [1023:0] d);
        int k;
        in_valid[i] = 1'b1;
        in_mode[i]  = m;
        in_data[i]  = d;
        k = 0;
        @(negedge clk);
        while (!in_ready[i] && k < 200) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (k == 200) begin
            bad++;
            $display("FAIL send%0d: in_ready got %b want 1 within 200 cycles", i, in_ready[i]);
        end
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
    endtask
    // Monitor: check the head of each scoreboard whenever output is valid, pop on handshake, push on accept.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                int n;
                item_t e;
                n = i == 0 ? q0.size() : q1.size();
                e = '0;
                if (n > 0) e = i == 0 ? q0[0] : q1[0];
                chkb(i == 0 ? "sb0_busy" : "sb1_busy", busy[i], n != 0);
                if (out_valid[i]) begin
                    if (n == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb%0d_extra: got out_valid=1 want 0 (no entry expected)", i);
                    end else begin
                        chkd(i == 0 ? "sb0_data" : "sb1_data", out_data[i], e.d);
                        chkb(i == 0 ? "sb0_mode" : "sb1_mode", out_mode[i], e.m);
                        if (out_ready[i]) begin
                            if (i == 0) void'(q0.pop_front());
                            else void'(q1.pop_front());
                        end
                    end
                end
                if (flush[i]) begin
                    chkb(i == 0 ? "sb0_flush_rdy" : "sb1_flush_rdy", in_ready[i], 1'b0);
                    if (i == 0) q0.delete();
                    else q1.delete();
                end else if (in_valid[i] && in_ready[i]) begin
                    e.d = model(in_data[i], in_mode[i], i == 0 ? 8 : 16);
                    e.m = in_mode[i];
                    if (i == 0) q0.push_back(e);
                    else q1.push_back(e);
                end
            end
        end
    end
    initial begin
        logic [1023:0] a, b, cc;
        for (int i = 0; i < 2; i++) begin
            flush[i] = 1'b0;
            in_valid[i] = 1'b0;
            in_mode[i] = 1'b0;
            in_data[i] = '0;
            out_ready[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chkb("rst_valid", out_valid[i], 1'b0);
            chkb("rst_busy", busy[i], 1'b0);
            chkb("rst_mode", out_mode[i], 1'b0);
            chkb("rst_data_nonzero", out_data[i] != '0, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chkb("rst_in_ready", in_ready[i], 1'b1);
        @(posedge clk);
        #1;
        send(0, 1'b0, pat(8));
        @(negedge clk);
        chkb("t1_valid", out_valid[0], 1'b1);
        chk("t1_col0", col(0, 0), 64'h0009121B242D363F);
        chk("t1_col1", col(0, 1), 64'h08111A232C353E07);
        chkb("t1_mode", out_mode[0], 1'b0);
        @(posedge clk);
        #1;
        send(0, 1'b1, pat(8));
        @(negedge clk);
        chk("t2_col0", col(0, 0), 64'h08192A3B04152637);
        chkb("t2_mode", out_mode[0], 1'b1);
        @(posedge clk);
        #1;
        send(1, 1'b0, pat(16));
        send(1, 1'b1, pat(16));
        @(negedge clk);
        chkb("t3_p_valid", out_valid[1], 1'b1);
        chk("t3_p_col0", col(1, 0), 64'h0009121B242D365F);
        chkb("t3_p_mode", out_mode[1], 1'b0);
        @(negedge clk);
        chkb("t3_q_valid", out_valid[1], 1'b1);
        chk("t3_q_col0", col(1, 0), 64'h08192A5B04152637);
        chkb("t3_q_mode", out_mode[1], 1'b1);
        @(posedge clk);
        #1;
        out_ready[1] = 1'b0;
        a = rnd();
        b = rnd();
        cc = rnd();
        in_valid[1] = 1'b1;
        in_mode[1] = 1'b0;
        in_data[1] = a;
        @(posedge clk);
        #1;
        in_mode[1] = 1'b1;
        in_data[1] = b;
        @(posedge clk);
        #1;
        in_mode[1] = 1'b0;
        in_data[1] = cc;
        repeat (5) begin
            @(negedge clk);
            chkb("t4_in_ready", in_ready[1], 1'b0);
            chkb("t4_busy", busy[1], 1'b1);
            chkd("t4_hold", out_data[1], model(a, 1'b0, 16));
        end
        @(posedge clk);
        #1;
        out_ready[1] = 1'b1;
        @(negedge clk);
        chkb("t4_v1", out_valid[1], 1'b1);
        chkd("t4_first", out_data[1], model(a, 1'b0, 16));
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        @(negedge clk);
        chkb("t4_v2", out_valid[1], 1'b1);
        chkd("t4_second", out_data[1], model(b, 1'b1, 16));
        @(negedge clk);
        chkb("t4_v3", out_valid[1], 1'b1);
        chkd("t4_third", out_data[1], model(cc, 1'b0, 16));
        @(posedge clk);
        #1;
        out_ready[1] = 1'b0;
        in_valid[1] = 1'b1;
        in_data[1] = rnd();
        @(posedge clk);
        #1;
        in_data[1] = rnd();
        @(posedge clk);
        #1;
        flush[1] = 1'b1;
        in_data[1] = rnd();
        @(negedge clk);
        chkb("t5_in_ready", in_ready[1], 1'b0);
        chkb("t5_busy_pre", busy[1], 1'b1);
        @(posedge clk);
        #1;
        flush[1] = 1'b0;
        in_valid[1] = 1'b0;
        @(negedge clk);
        chkb("t5_valid", out_valid[1], 1'b0);
        chkb("t5_busy", busy[1], 1'b0);
        chkb("t5_ready", in_ready[1], 1'b1);
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        in_valid[0] = 1'b1;
        in_data[0] = rnd();
        in_valid[1] = 1'b1;
        in_data[1] = rnd();
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        in_data[1] = rnd();
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chkb("t6_valid", out_valid[i], 1'b0);
            chkb("t6_busy", busy[i], 1'b0);
            chkb("t6_mode", out_mode[i], 1'b0);
            chkb("t6_data_nonzero", out_data[i] != '0, 1'b0);
        end
        q0.delete();
        q1.delete();
        #1;
        rst_n = 1'b1;
        out_ready[0] = 1'b1;
        out_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        a = rnd();
        send(1, 1'b1, a);
        @(negedge clk);
        chkb("t6_early_valid", out_valid[1], 1'b0);
        @(negedge clk);
        chkb("t6_lat_valid", out_valid[1], 1'b1);
        chkd("t6_data", out_data[1], model(a, 1'b1, 16));
        @(posedge clk);
        #1;
        repeat (3000) begin
            for (int i = 0; i < 2; i++) begin
                in_valid[i] = $urandom_range(3) != 0;
                in_mode[i] = 1'($urandom_range(1));
                in_data[i] = rnd();
                out_ready[i] = $urandom_range(3) != 0;
                flush[i] = $urandom_range(63) == 0;
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0;
            flush[i] = 1'b0;
            out_ready[i] = 1'b1;
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("drain_q0", 64'(q0.size()), 64'h0);
        chk("drain_q1", 64'(q1.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
